// File: rtl/dmem_arbiter_if.sv
// Per-master request/response port of the data-memory arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              req;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   we;
  logic              gnt;
  logic              rvalid;
  logic [DW-1:0]     rdata;

  modport master (output req, addr, wdata, we, input gnt, rvalid, rdata);
  modport slave  (input req, addr, wdata, we, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for the CPU data memory port.
// Writes issue one per cycle; reads take IDLE->RD and return registered data
// to the issuing master two cycles after the grant.
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie breaking
// (default is fixed priority, master 0 wins).
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [AW-1:0]     daddr,
  output logic [DW-1:0]     dwdata,
  output logic [DW/8-1:0]   dwe,
  input  logic [DW-1:0]     drdata
);

  typedef enum logic {IDLE = 1'b0, RD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [1:0]            req, gnt;
  logic                  sel, is_wr, win;
  logic [DW/8-1:0]       sel_we;
  logic                  owner_q, owner_d;
  logic [AW-1:0]         daddr_q, daddr_d;
  logic [DW-1:0]         dwdata_q, dwdata_d;
  logic [DW/8-1:0]       dwe_q, dwe_d;
  logic [1:0][DW-1:0]    rdata_q, rdata_d;
  logic [1:0]            rvalid_q, rvalid_d;

  assign req    = {m1.req, m0.req};
  assign sel    = gnt[1];
  assign sel_we = sel ? m1.we : m0.we;
  assign is_wr  = |sel_we;

`ifdef DMEM_ARB_RR_EN
  // last_q holds the index of the most recently granted master
  logic last_q, last_d;
  assign win = ~last_q;

  // pointer follows every grant, contested or not
  always_comb begin
    last_d = last_q;
    if (|gnt) last_d = sel;
  end

  // round-robin pointer register; reset to 1 so master 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  assign win = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state: an accepted read enters RD, RD always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|gnt && !is_wr) state_d = RD;
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant decode: only in IDLE, ties broken by win (0 -> m0, 1 -> m1)
  always_comb begin
    gnt = '0;
    if (state_q == IDLE) begin
      if (req == 2'b11) gnt = win ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // datapath next values: launch granted request, capture read data in RD
  always_comb begin
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    dwe_d    = '0;
    owner_d  = owner_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    if (|gnt) begin
      daddr_d = sel ? m1.addr : m0.addr;
      dwe_d   = sel_we;
      if (is_wr) dwdata_d = sel ? m1.wdata : m0.wdata;
      else       owner_d  = sel;
    end
    if (state_q == RD) begin
      rdata_d[owner_q]  = drdata;
      rvalid_d[owner_q] = 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      daddr_q  <= '0;
      dwdata_q <= '0;
      dwe_q    <= '0;
      owner_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      dwe_q    <= dwe_d;
      owner_q  <= owner_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign daddr     = daddr_q;
  assign dwdata    = dwdata_q;
  assign dwe       = dwe_q;
  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata_q[0];
  assign m1.rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-data scoreboard per master.
// Tie expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic [DW/8-1:0] dwe;
  logic [DW-1:0] drdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  dmem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  dmem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  always #5 clk = ~clk;

  // combinational memory model
  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb drdata = mem_model(daddr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(posedge clk); #1;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  // scoreboard: push expected data at read grant, pop at rvalid
  always @(negedge clk) begin
    if (reset_n) begin
      if (m0_if.rvalid) begin
        if (q0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
        else                chk("m0_rdata", m0_if.rdata, q0.pop_front());
      end
      if (m1_if.rvalid) begin
        if (q1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
        else                chk("m1_rdata", m1_if.rdata, q1.pop_front());
      end
      if (m0_if.gnt && m0_if.we == '0) q0.push_back(mem_model(m0_if.addr));
      if (m1_if.gnt && m1_if.we == '0) q1.push_back(mem_model(m1_if.addr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    m0_if.req = 0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.we = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.we = '0;
    #2;
    chk("rst_daddr", daddr, 0);
    chk("rst_dwe", dwe, 0);
    chk("rst_rvalid", {m1_if.rvalid, m0_if.rvalid}, 0);
    chk("rst_rdata0", m0_if.rdata, 0);
    nx(); nx();
    reset_n = 1'b1;
    nx();

    // single write from m0
    m0_if.req = 1; m0_if.addr = 32'h100; m0_if.wdata = 32'hDEAD_BEEF; m0_if.we = 4'hF;
    sm(); chk("wr_gnt", {m1_if.gnt, m0_if.gnt}, 2'b01);
    nx(); m0_if.req = 0; m0_if.we = 0;
    sm(); chk("wr_daddr", daddr, 32'h100);
    chk("wr_dwdata", dwdata, 32'hDEAD_BEEF);
    chk("wr_dwe", dwe, 4'hF);
    nx(); sm(); chk("wr_dwe_clr", dwe, 0);
    chk("wr_hold_daddr", daddr, 32'h100);

    // single read from m1
    nx(); m1_if.req = 1; m1_if.addr = 32'h40; m1_if.we = 0;
    sm(); chk("rd_gnt", {m1_if.gnt, m0_if.gnt}, 2'b10);
    nx(); m1_if.req = 0;
    sm(); chk("rd_daddr", daddr, 32'h40);
    chk("rd_dwe", dwe, 0);
    nx(); sm();
    chk("rd_m1_rvalid", m1_if.rvalid, 1);
    chk("rd_m1_rdata", m1_if.rdata, 32'h1234_5678);
    chk("rd_m0_rvalid", m0_if.rvalid, 0);
    nx(); sm(); chk("rd_rvalid_pulse", m1_if.rvalid, 0);

    // three back-to-back writes then a read
    for (int k = 0; k < 3; k++) begin
      m0_if.req = 1; m0_if.addr = 32'h1000 + 4 * k; m0_if.wdata = 32'hA0 + k; m0_if.we = 4'hF;
      sm(); chk("b2b_wr_gnt", m0_if.gnt, 1);
      if (k > 0) chk("b2b_dwe", dwe, 4'hF);
      nx();
    end
    m0_if.addr = 32'h200; m0_if.we = 0;
    sm(); chk("b2b_rd_gnt", m0_if.gnt, 1);
    chk("b2b_dwe3", dwe, 4'hF);
    chk("b2b_daddr3", daddr, 32'h1008);
    nx(); m0_if.addr = 32'h300; m0_if.wdata = 32'h5555_AAAA; m0_if.we = 4'hF;
    sm(); chk("b2b_rd_block", m0_if.gnt, 0);
    chk("b2b_rd_daddr", daddr, 32'h200);
    chk("b2b_rd_dwe", dwe, 0);
    nx(); sm();
    chk("b2b_wr_after_rd_gnt", m0_if.gnt, 1);
    chk("b2b_rvalid", m0_if.rvalid, 1);
    nx(); m0_if.req = 0; m0_if.we = 0;
    sm(); chk("b2b_last_dwe", dwe, 4'hF);
    chk("b2b_last_daddr", daddr, 32'h300);
    chk("m1_rdata_hold", m1_if.rdata, 32'h1234_5678);

    // tie: both masters request reads continuously
    nx();
    m0_if.req = 1; m0_if.addr = 32'h10; m0_if.we = 0;
    m1_if.req = 1; m1_if.addr = 32'h20; m1_if.we = 0;
    for (int c = 0; c < 8; c++) begin
      logic [1:0] exp_g;
      exp_g = 2'b00;
      if (c % 2 == 0) begin
`ifdef DMEM_ARB_RR_EN
        exp_g = (c % 4 == 0) ? 2'b10 : 2'b01;
`else
        exp_g = 2'b01;
`endif
      end
      sm(); chk($sformatf("tie_gnt_c%0d", c), {m1_if.gnt, m0_if.gnt}, exp_g);
      nx();
    end
    m0_if.req = 0;
    sm(); chk("tie_m1_after_m0_drop", {m1_if.gnt, m0_if.gnt}, 2'b10);
    nx(); m1_if.req = 0;
    nx(); nx();

    // reset while a read is in RD
    m0_if.req = 1; m0_if.addr = 32'h80; m0_if.we = 0;
    sm(); chk("rst_rd_gnt", m0_if.gnt, 1);
    nx(); m0_if.req = 0;
    #2; reset_n = 1'b0; q0.delete(); q1.delete();
    sm();
    chk("rstrd_daddr", daddr, 0);
    chk("rstrd_dwdata", dwdata, 0);
    chk("rstrd_dwe", dwe, 0);
    chk("rstrd_rvalid", {m1_if.rvalid, m0_if.rvalid}, 0);
    chk("rstrd_rdata", {m1_if.rdata, m0_if.rdata}, 0);
    chk("rstrd_gnt", {m1_if.gnt, m0_if.gnt}, 0);
    nx(); nx();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sm(); chk("post_rst_rvalid", {m1_if.rvalid, m0_if.rvalid}, 0);
      nx();
    end
    m1_if.req = 1; m1_if.addr = 32'h44; m1_if.wdata = 32'hCAFE_F00D; m1_if.we = 4'b0011;
    sm(); chk("post_rst_gnt", {m1_if.gnt, m0_if.gnt}, 2'b10);
    nx(); m1_if.req = 0; m1_if.we = 0;
    sm(); chk("post_rst_dwe", dwe, 4'b0011);
    chk("post_rst_daddr", daddr, 32'h44);
    chk("post_rst_dwdata", dwdata, 32'hCAFE_F00D);
    nx(); nx();
    chk("sb_q0_empty", q0.size(), 0);
    chk("sb_q1_empty", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
